// File: rtl/bus_demux3_pkg.sv
// Shared types and constants for the three-target data-bus demultiplexer.
// Default base/mask pairs select the RAM, MMIO and timer regions.
package bus_demux3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] T_RAM  = 2'd0;
  localparam logic [1:0] T_MMIO = 2'd1;
  localparam logic [1:0] T_TMR  = 2'd2;

  localparam logic [31:0] DEF_T0_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_T0_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DEF_T1_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_T1_MASK = 32'hFFFF_F000;
  localparam logic [31:0] DEF_T2_BASE = 32'h2000_0000;
  localparam logic [31:0] DEF_T2_MASK = 32'hFFFF_FF00;

  // Binary target index of a priority-resolved one-hot hit vector.
  function automatic logic [1:0] sel_of(input logic [2:0] hit);
    if (hit[0])      return T_RAM;
    else if (hit[1]) return T_MMIO;
    else             return T_TMR;
  endfunction

endpackage

// File: rtl/bus_addr_decode3.sv
// Combinational base/mask address decoder for three targets.
// Overlapping regions resolve to the lowest target index.
module bus_addr_decode3
  import bus_demux3_pkg::*;
#(
  parameter int            AW      = 32,
  parameter logic [AW-1:0] T0_BASE = DEF_T0_BASE[AW-1:0],
  parameter logic [AW-1:0] T0_MASK = DEF_T0_MASK[AW-1:0],
  parameter logic [AW-1:0] T1_BASE = DEF_T1_BASE[AW-1:0],
  parameter logic [AW-1:0] T1_MASK = DEF_T1_MASK[AW-1:0],
  parameter logic [AW-1:0] T2_BASE = DEF_T2_BASE[AW-1:0],
  parameter logic [AW-1:0] T2_MASK = DEF_T2_MASK[AW-1:0]
) (
  input  logic [AW-1:0] i_addr,
  output logic [2:0]    o_hit,
  output logic          o_miss
);

  logic [2:0] w_raw;

  assign w_raw[T_RAM]  = ((i_addr & T0_MASK) == T0_BASE);
  assign w_raw[T_MMIO] = ((i_addr & T1_MASK) == T1_BASE);
  assign w_raw[T_TMR]  = ((i_addr & T2_MASK) == T2_BASE);

  assign o_hit  = w_raw[0] ? 3'b001 :
                  w_raw[1] ? 3'b010 :
                  w_raw[2] ? 3'b100 : 3'b000;
  assign o_miss = ~|w_raw;

endmodule

// File: rtl/mux3.sv
// Three-input W-bit multiplexer; selector codes 0/1/2 pick d0/d1/d2.
module mux3 #(
  parameter int W = 32
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  output logic [W-1:0] o_q
);

  // NOTE: o_q gets a default before the case so no code path can infer a latch.
  always_comb begin
    o_q = '0;
    case (i_sel)
      2'd0:    o_q = i_d0;
      2'd1:    o_q = i_d1;
      2'd2:    o_q = i_d2;
      default: o_q = '0;
    endcase
  end

endmodule

// File: rtl/bus_demux3.sv
// One-outstanding-transaction demux from the core data port to RAM, MMIO
// and timer targets, with a per-transaction handshake timeout.
module bus_demux3
  import bus_demux3_pkg::*;
#(
  parameter int            AW      = 32,
  parameter int            DW      = 32,
  parameter logic [AW-1:0] T0_BASE = DEF_T0_BASE[AW-1:0],
  parameter logic [AW-1:0] T0_MASK = DEF_T0_MASK[AW-1:0],
  parameter logic [AW-1:0] T1_BASE = DEF_T1_BASE[AW-1:0],
  parameter logic [AW-1:0] T1_MASK = DEF_T1_MASK[AW-1:0],
  parameter logic [AW-1:0] T2_BASE = DEF_T2_BASE[AW-1:0],
  parameter logic [AW-1:0] T2_MASK = DEF_T2_MASK[AW-1:0],
  parameter int            TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m_req,
  input  logic            m_we,
  input  logic [AW-1:0]   m_addr,
  input  logic [DW-1:0]   m_wdata,
  input  logic [DW/8-1:0] m_be,
  output logic            m_ready,
  output logic [DW-1:0]   m_rdata,
  output logic            m_err,
  output logic [2:0]      s_req,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_be,
  input  logic [2:0]      s_ready,
  input  logic [DW-1:0]   s_rdata0,
  input  logic [DW-1:0]   s_rdata1,
  input  logic [DW-1:0]   s_rdata2
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_e          r_state;
  logic [1:0]      r_sel;
  logic [15:0]     r_cnt;
  logic [2:0]      r_s_req;
  logic            r_s_we;
  logic [AW-1:0]   r_s_addr;
  logic [DW-1:0]   r_s_wdata;
  logic [DW/8-1:0] r_s_be;
  logic            r_m_ready;
  logic            r_m_err;
  logic [DW-1:0]   r_m_rdata;

  logic [2:0]      w_hit;
  logic            w_miss;
  logic [DW-1:0]   w_rdata;
  logic            w_sel_ready;

  bus_addr_decode3 #(
    .AW(AW),
    .T0_BASE(T0_BASE), .T0_MASK(T0_MASK),
    .T1_BASE(T1_BASE), .T1_MASK(T1_MASK),
    .T2_BASE(T2_BASE), .T2_MASK(T2_MASK)
  ) u_decode (
    .i_addr (m_addr),
    .o_hit  (w_hit),
    .o_miss (w_miss)
  );

  mux3 #(.W(DW)) u_rdata_mux (
    .i_sel (r_sel),
    .i_d0  (s_rdata0),
    .i_d1  (s_rdata1),
    .i_d2  (s_rdata2),
    .o_q   (w_rdata)
  );

  // r_s_req is one-hot on the selected target, so this masks stray readies.
  assign w_sel_ready = |(s_ready & r_s_req);

  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel     <= T_RAM;
      r_cnt     <= '0;
      r_s_req   <= '0;
      r_s_we    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_be    <= '0;
      r_m_ready <= 1'b0;
      r_m_err   <= 1'b0;
      r_m_rdata <= '0;
    end else begin
      r_m_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m_req) begin
            if (w_miss) begin
              r_m_err   <= 1'b1;
              r_m_rdata <= '0;
              r_m_ready <= 1'b1;
              r_state   <= RESP;
            end else begin
              r_s_we    <= m_we;
              r_s_addr  <= m_addr;
              r_s_wdata <= m_wdata;
              r_s_be    <= m_be;
              r_sel     <= sel_of(w_hit);
              r_s_req   <= w_hit;
              r_cnt     <= '0;
              r_state   <= BUSY;
            end
          end
        end
        BUSY: begin
          // Ready wins over a timeout landing in the same cycle.
          if (w_sel_ready) begin
            r_m_rdata <= r_s_we ? '0 : w_rdata;
            r_m_err   <= 1'b0;
            r_s_req   <= '0;
            r_m_ready <= 1'b1;
            r_state   <= RESP;
          end else if (r_cnt + 16'd1 == TO_LIM) begin
            r_m_rdata <= '0;
            r_m_err   <= 1'b1;
            r_s_req   <= '0;
            r_m_ready <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_ready = r_m_ready;
  assign m_rdata = r_m_rdata;
  assign m_err   = r_m_err;
  assign s_req   = r_s_req;
  assign s_we    = r_s_we;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign s_be    = r_s_be;

endmodule

// File: tb/tb_bus_demux3.sv
// Directed self-checking bench for bus_demux3 (TIMEOUT=4): reset mid-BUSY,
// store, decode miss, timeout edge cases, stray ready and back-to-back loads.
module tb_bus_demux3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [2:0]  s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [2:0]  s_ready;
  logic [31:0] s_rdata0;
  logic [31:0] s_rdata1;
  logic [31:0] s_rdata2;

  int n_checks = 0;
  int n_fail   = 0;

  bus_demux3 #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_be     (s_be),
    .s_ready  (s_ready),
    .s_rdata0 (s_rdata0),
    .s_rdata1 (s_rdata1),
    .s_rdata2 (s_rdata2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    m_req   = 1'b1;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    m_be    = be;
  endtask

  // Called in the cycle after m_ready: release the request and confirm the pulse ended.
  task automatic finish_txn(input string tag);
    tick();
    m_req = 1'b0;
    @(negedge clk);
    check({tag, "_ready_pulse_end"}, 32'(m_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_ready = '0; s_rdata0 = '0; s_rdata1 = '0; s_rdata2 = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_s_req",   32'(s_req),   32'd0);
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_m_err",   32'(m_err),   32'd0);
    check("rst_m_rdata", m_rdata,      32'd0);
    check("rst_s_addr",  s_addr,       32'd0);
    tick();
    rst_n = 1'b1;

    // Reset mid-BUSY with T1 stalling
    drive_req(1'b0, 32'h1000_0004, 32'h0, 4'hF);
    tick();
    @(negedge clk);
    check("rb_s_req_busy", 32'(s_req), 32'b010);
    tick();
    rst_n = 1'b0;
    #1;
    check("rb_s_req_async", 32'(s_req),   32'd0);
    check("rb_ready_async", 32'(m_ready), 32'd0);
    m_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    drive_req(1'b0, 32'h1000_0004, 32'h0, 4'hF);
    tick();
    s_ready = 3'b010; s_rdata1 = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rb_ready_early", 32'(m_ready), 32'd0);
    check("rb_s_addr",      s_addr,       32'h1000_0004);
    tick();
    s_ready = '0;
    @(negedge clk);
    check("rb_ready",  32'(m_ready), 32'd1);
    check("rb_rdata",  m_rdata,      32'hDEAD_BEEF);
    check("rb_err",    32'(m_err),   32'd0);
    finish_txn("rb");

    // Decode miss
    drive_req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    tick();
    @(negedge clk);
    check("miss_s_req", 32'(s_req),   32'd0);
    check("miss_ready", 32'(m_ready), 32'd1);
    check("miss_err",   32'(m_err),   32'd1);
    check("miss_rdata", m_rdata,      32'd0);
    finish_txn("miss");
    check("miss_s_req_after", 32'(s_req), 32'd0);

    // Store to T2, ready on the third BUSY cycle
    drive_req(1'b1, 32'h2000_0010, 32'h0000_00FF, 4'b0001);
    s_rdata2 = 32'h5555_AAAA;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) s_ready = 3'b100;
      @(negedge clk);
      check($sformatf("st_s_req_%0d", i), 32'(s_req), 32'b100);
      tick();
    end
    s_ready = '0;
    @(negedge clk);
    check("st_s_we",    32'(s_we),    32'd1);
    check("st_s_addr",  s_addr,       32'h2000_0010);
    check("st_s_wdata", s_wdata,      32'h0000_00FF);
    check("st_s_be",    32'(s_be),    32'b0001);
    check("st_s_req_drop", 32'(s_req), 32'd0);
    check("st_ready",   32'(m_ready), 32'd1);
    check("st_err",     32'(m_err),   32'd0);
    check("st_rdata",   m_rdata,      32'd0);
    finish_txn("st");

    // Ready on the 4th BUSY cycle (same cycle the count expires) succeeds
    drive_req(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin s_ready = 3'b001; s_rdata0 = 32'h1234_5678; end
      @(negedge clk);
      check($sformatf("tok_s_req_%0d", i), 32'(s_req), 32'b001);
      tick();
    end
    s_ready = '0;
    @(negedge clk);
    check("tok_ready", 32'(m_ready), 32'd1);
    check("tok_err",   32'(m_err),   32'd0);
    check("tok_rdata", m_rdata,      32'h1234_5678);
    finish_txn("tok");

    // Timeout: no ready for 4 BUSY cycles
    drive_req(1'b0, 32'h0000_0080, 32'h0, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("to_s_req_%0d", i), 32'(s_req), 32'b001);
      tick();
    end
    @(negedge clk);
    check("to_s_req_drop", 32'(s_req),   32'd0);
    check("to_ready",      32'(m_ready), 32'd1);
    check("to_err",        32'(m_err),   32'd1);
    check("to_rdata",      m_rdata,      32'd0);
    finish_txn("to");

    // Stray ready from T2 while T0 is selected
    drive_req(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    s_rdata0 = 32'hA5A5_0001;
    tick();
    s_ready = 3'b100; s_rdata2 = 32'hBAD0_BAD0;
    tick();
    s_ready = '0;
    @(negedge clk);
    check("stray_ready", 32'(m_ready), 32'd0);
    check("stray_s_req", 32'(s_req),   32'b001);
    s_ready = 3'b001;
    tick();
    s_ready = '0;
    @(negedge clk);
    check("stray_done_ready", 32'(m_ready), 32'd1);
    check("stray_done_rdata", m_rdata,      32'hA5A5_0001);

    // Back-to-back: next load presented in the cycle right after m_ready
    tick();
    drive_req(1'b0, 32'h1000_0008, 32'h0, 4'hF);
    s_rdata1 = 32'hC0DE_0002;
    @(negedge clk);
    check("b2b_idle_s_req", 32'(s_req),   32'd0);
    check("b2b_idle_ready", 32'(m_ready), 32'd0);
    tick();
    check("b2b_accept_s_req", 32'(s_req), 32'b010);
    s_ready = 3'b010;
    tick();
    s_ready = '0;
    @(negedge clk);
    check("b2b_ready", 32'(m_ready), 32'd1);
    check("b2b_rdata", m_rdata,      32'hC0DE_0002);
    check("b2b_err",   32'(m_err),   32'd0);
    finish_txn("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_demux3.md
Name: bus_demux3

Overview:
- Routes one initiator load/store transaction to one of three memory-mapped targets: T0 data RAM, T1 MMIO peripheral, T2 timer.
- Returns the selected target's read data and a completion pulse to the initiator.
- Sits between the core's data-memory port and the data-side targets.
- Holds one transaction in flight, waits for a target handshake, and enforces a timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- T0_BASE, 32'h0000_0000, T0 region base.
- T0_MASK, 32'hFFFF_0000, T0 decode mask.
- T1_BASE, 32'h1000_0000, T1 region base.
- T1_MASK, 32'hFFFF_F000, T1 decode mask.
- T2_BASE, 32'h2000_0000, T2 region base.
- T2_MASK, 32'hFFFF_FF00, T2 decode mask.
- TIMEOUT, 255, maximum BUSY cycles before an error response; 1..65535.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_req  in  1  initiator request; held until m_ready.
- m_we  in  1  1 = store, 0 = load.
- m_addr  in  AW  byte address.
- m_wdata  in  DW  store data.
- m_be  in  DW/8  byte enables.
- m_ready  out  1  one-cycle completion pulse.
- m_rdata  out  DW  load data; valid only while m_ready=1.
- m_err  out  1  error flag; valid only while m_ready=1.
- s_req  out  3  one-hot target request.
- s_we  out  1  registered copy of m_we, broadcast to all targets.
- s_addr  out  AW  registered copy of m_addr, broadcast.
- s_wdata  out  DW  registered copy of m_wdata, broadcast.
- s_be  out  DW/8  registered copy of m_be, broadcast.
- s_ready  in  3  per-target completion.
- s_rdata0, s_rdata1, s_rdata2  in  DW each  per-target read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, s_req=0, m_ready=0, m_err=0, m_rdata=0.
  - s_we/s_addr/s_wdata/s_be=0, sel=0, timeout counter=0.
  - Takes effect immediately, including mid-transaction; s_req drops without waiting for s_ready.
- Decode: target k hits when (m_addr & Tk_MASK)==Tk_BASE. Overlapping hits resolve to the lowest index. No hit means a decode miss.
- States: IDLE, BUSY, RESP.
- IDLE:
  - m_req is sampled only in this state.
  - m_req=1 with a hit: latch we/addr/wdata/be into the s_* registers, latch sel, clear the counter, go to BUSY. s_req[sel]=1 from the next cycle.
  - m_req=1 with a miss: go to RESP with m_err=1 and m_rdata=0. No target is touched.
- BUSY:
  - s_req[sel] is held at 1; the other s_req bits are 0.
  - s_ready bits of non-selected targets are ignored.
  - s_ready[sel]=1: capture the selected s_rdata (load) or 0 (store) into m_rdata, m_err=0, s_req=0, go to RESP.
  - Else the counter increments. On reaching TIMEOUT with no ready: s_req=0, m_err=1, m_rdata=0, go to RESP.
  - s_ready[sel] in the same cycle the counter reaches TIMEOUT counts as success.
- RESP:
  - m_ready=1 for exactly one cycle, then IDLE.
  - m_rdata/m_err stay stable until the next RESP; only meaningful while m_ready=1.
- Latency:
  - Request accepted at edge N; s_req visible in cycle N+1.
  - s_ready sampled at edge M; m_ready high in cycle M+1.
  - Minimum hit transaction (target ready on first BUSY cycle): m_ready 2 cycles after acceptance.
  - Decode miss: m_ready 1 cycle after acceptance.
- Initiator rules:
  - Hold m_req and all operands stable until m_ready.
  - Deassert m_req in the cycle after m_ready, or it is taken as a new transaction in IDLE.
  - Back-to-back rate: one transaction per 3 cycles minimum.
- Operands arriving while in BUSY/RESP are ignored; the s_* outputs keep their latched values.

Decomposition:
- Package bus_demux3_pkg:
  - state enum (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - target index constants (T_RAM=0, T_MMIO=1, T_TMR=2);
  - default base/mask localparams.
- Sub-module bus_addr_decode3: combinational; inputs addr; outputs hit[2:0] (priority-resolved one-hot) and miss.
- Read-data return path uses the existing mux3 instantiated with W=DW.
  - sel encoding: T0=2'b00, T1=2'b01, T2=2'b10.

Test Plan:
- Reset mid-BUSY:
  - Load to 0x1000_0004, T1 stalls; drop rst_n in BUSY.
  - Required: s_req=0 and m_ready=0 immediately. After release, a fresh load to 0x1000_0004 with s_ready[1] in the first BUSY cycle and s_rdata1=32'hDEAD_BEEF gives m_ready 2 cycles after acceptance, m_rdata=32'hDEAD_BEEF, m_err=0.
- Store to T2:
  - Store to 0x2000_0010, wdata=32'h0000_00FF, be=4'b0001; T2 ready after 3 cycles.
  - Required: s_req=3'b100 for exactly 3 cycles; s_addr/s_wdata/s_be match; m_ready one pulse with m_err=0.
- Decode miss:
  - Load to 0x3000_0000.
  - Required: s_req stays 0; m_ready 1 cycle later with m_err=1, m_rdata=0.
- Timeout:
  - TIMEOUT=4; load to T0, s_ready held 0.
  - Required: s_req[0] high 4 cycles then drops; m_ready with m_err=1, m_rdata=0.
  - With s_ready[0] in the 4th BUSY cycle instead: m_err=0.
- Stray ready and back-to-back:
  - s_ready[2] pulsed while T0 is selected.
  - Required: ignored, no completion.
  - Two loads to T0 and T1 with m_req reasserted the cycle after m_ready: both complete, with acceptances 3 cycles apart when both targets respond on their first BUSY cycle.
